// File: rtl/mem_req_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_req_sequencer : write/read arbiter with credit-protected read-response FIFO
//                     in front of a single-port SRAM.                Rev 1.0
// -----------------------------------------------------------------------------
module mem_req_sequencer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              mem_chip_en_o,
  output logic              mem_wr_en_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              busy_o
);

  localparam int C_PTR_W = $clog2(RSP_DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W:0]   C_CREDITS = (C_CNT_W + 1)'(RSP_DEPTH);
  localparam logic [C_CNT_W-1:0] C_FULL    = C_CNT_W'(RSP_DEPTH);
  localparam logic [C_CNT_W-1:0] C_ONE     = C_CNT_W'(1);

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

  grant_e              last_gnt_q;
  logic                mem_chip_en_q;
  logic                mem_wr_en_q;
  logic                mem_rd_en_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wr_data_q;

  logic [RD_LAT-1:0]   rd_pipe_q;
  logic [RD_LAT-1:0]   rd_pipe_d;
  logic [C_CNT_W-1:0]  inflight_q;
  logic [C_CNT_W-1:0]  inflight_d;

  logic [DATA_W-1:0]   fifo_mem_q [RSP_DEPTH];
  logic [C_PTR_W-1:0]  wr_ptr_q;
  logic [C_PTR_W-1:0]  rd_ptr_q;
  logic [C_CNT_W-1:0]  fifo_count_q;
  logic [C_CNT_W-1:0]  fifo_count_d;

  logic [C_CNT_W:0]    credit_used;
  logic                rd_credit_ok;
  logic                wr_cand;
  logic                rd_cand;
  logic                gnt_wr;
  logic                gnt_rd;
  logic                push;
  logic                pop;

  // Reads are charged a credit at grant time so a read granted in the cycle
  // before its mem_rd_en rises is already counted against the FIFO space.
  assign credit_used  = {1'b0, inflight_q} + {1'b0, fifo_count_q};
  assign rd_credit_ok = credit_used < C_CREDITS;

  assign wr_cand = wr_valid_i & rst_ni;
  assign rd_cand = rd_valid_i & rd_credit_ok & rst_ni;
  assign gnt_wr  = wr_cand & (~rd_cand | (last_gnt_q == GNT_RD));
  assign gnt_rd  = rd_cand & (~wr_cand | (last_gnt_q == GNT_WR));

  assign wr_ready_o = gnt_wr;
  assign rd_ready_o = gnt_rd;

  assign push = rd_pipe_q[RD_LAT-1];
  assign pop  = rsp_valid_o & rsp_ready_i;

  always_comb begin
    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = mem_rd_en_q;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (gnt_rd && !push) begin
      inflight_d = inflight_q + C_ONE;
    end else if (!gnt_rd && push) begin
      inflight_d = inflight_q - C_ONE;
    end
  end

  always_comb begin
    fifo_count_d = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + C_ONE;
    end else if (pop && !push) begin
      fifo_count_d = fifo_count_q - C_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_q    <= GNT_RD;
      mem_chip_en_q <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_pipe_q     <= '0;
      inflight_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
    end else begin
      mem_chip_en_q <= gnt_wr | gnt_rd;
      mem_wr_en_q   <= gnt_wr;
      mem_rd_en_q   <= gnt_rd;
      if (gnt_wr) begin
        mem_addr_q    <= wr_addr_i;
        mem_wr_data_q <= wr_data_i;
        last_gnt_q    <= GNT_WR;
      end else if (gnt_rd) begin
        mem_addr_q    <= rd_addr_i;
        last_gnt_q    <= GNT_RD;
      end
      rd_pipe_q    <= rd_pipe_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: validity is carried entirely by fifo_count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= mem_rd_data_i;
    end
  end

  assign rsp_valid_o   = (fifo_count_q != '0);
  assign rsp_data_o    = fifo_mem_q[rd_ptr_q];
  assign busy_o        = (inflight_q != '0) | (fifo_count_q != '0);

  assign mem_chip_en_o = mem_chip_en_q;
  assign mem_wr_en_o   = mem_wr_en_q;
  assign mem_rd_en_o   = mem_rd_en_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wr_data_q;

  a_no_fifo_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (fifo_count_q == C_FULL)));

  a_inflight_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(gnt_rd && !push && (inflight_q == C_FULL)));

  a_inflight_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (inflight_q == '0)));

endmodule
`default_nettype wire

// File: tb/tb_mem_req_sequencer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mem_req_sequencer : directed bench for mem_req_sequencer (RD_LAT 1 and 3).
//                                                                  Rev 1.0
// -----------------------------------------------------------------------------
module tb_mem_req_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Default build (RD_LAT=1)
  logic        wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
  logic [9:0]  wr_addr, rd_addr, mem_addr;
  logic [15:0] wr_data, rsp_data, mem_wr_data, mem_rd_data;
  logic        mem_chip_en, mem_wr_en, mem_rd_en, busy;

  // RD_LAT=3 build
  logic        wr_valid3, wr_ready3, rd_valid3, rd_ready3, rsp_valid3, rsp_ready3;
  logic [9:0]  wr_addr3, rd_addr3, mem_addr3;
  logic [15:0] wr_data3, rsp_data3, mem_wr_data3, mem_rd_data3;
  logic        mem_chip_en3, mem_wr_en3, mem_rd_en3, busy3;

  int checks   = 0;
  int failures = 0;

  mem_req_sequencer #(.DATA_W(16), .ADDR_W(10), .RD_LAT(1), .RSP_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .mem_chip_en_o(mem_chip_en), .mem_wr_en_o(mem_wr_en), .mem_rd_en_o(mem_rd_en),
    .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data), .mem_rd_data_i(mem_rd_data),
    .busy_o(busy)
  );

  mem_req_sequencer #(.DATA_W(16), .ADDR_W(10), .RD_LAT(3), .RSP_DEPTH(4)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_valid_i(wr_valid3), .wr_ready_o(wr_ready3), .wr_addr_i(wr_addr3), .wr_data_i(wr_data3),
    .rd_valid_i(rd_valid3), .rd_ready_o(rd_ready3), .rd_addr_i(rd_addr3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_data_o(rsp_data3),
    .mem_chip_en_o(mem_chip_en3), .mem_wr_en_o(mem_wr_en3), .mem_rd_en_o(mem_rd_en3),
    .mem_addr_o(mem_addr3), .mem_wr_data_o(mem_wr_data3), .mem_rd_data_i(mem_rd_data3),
    .busy_o(busy3)
  );

  // SRAM model, 1-cycle read latency
  logic [15:0] sram1 [0:1023];
  always @(posedge clk) begin
    if (mem_chip_en && mem_wr_en) sram1[mem_addr] <= mem_wr_data;
    if (mem_chip_en && mem_rd_en) mem_rd_data <= sram1[mem_addr];
  end

  // SRAM model, 3-cycle read latency, read-only (preloaded)
  logic [15:0] sram3 [0:1023];
  logic [15:0] s3_0, s3_1;
  always @(posedge clk) begin
    if (mem_chip_en3 && mem_rd_en3) s3_0 <= sram3[mem_addr3];
    s3_1         <= s3_0;
    mem_rd_data3 <= s3_1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [9:0]  addr_tab [4];
  logic [15:0] data_tab [4];
  int nw, nr, na;

  initial begin
    addr_tab[0] = 10'h100; data_tab[0] = 16'hA000;
    addr_tab[1] = 10'h101; data_tab[1] = 16'hA001;
    addr_tab[2] = 10'h102; data_tab[2] = 16'hA002;
    addr_tab[3] = 10'h155; data_tab[3] = 16'h3A5C;
    sram3[10'h2AA] = 16'hBEEF;

    wr_valid = 0; rd_valid = 0; rsp_ready = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    wr_valid3 = 0; rd_valid3 = 0; rsp_ready3 = 0; wr_addr3 = '0; rd_addr3 = '0; wr_data3 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state, with requests offered while held in reset
    repeat (3) @(negedge clk);
    wr_valid = 1; rd_valid = 1; #1;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_chip_en", mem_chip_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    wr_valid = 0; rd_valid = 0;
    rst_n = 1'b1;

    // 1: write 0x3A5C to 0x155, then read it back
    @(negedge clk);
    wr_valid = 1; wr_addr = 10'h155; wr_data = 16'h3A5C; #1;
    check("t1_wr_ready", wr_ready, 1);
    @(negedge clk);
    wr_valid = 0; rd_valid = 1; rd_addr = 10'h155; #1;
    check("t1_mem_chip_en", mem_chip_en, 1);
    check("t1_mem_wr_en", mem_wr_en, 1);
    check("t1_mem_rd_en", mem_rd_en, 0);
    check("t1_mem_addr_wr", mem_addr, 10'h155);
    check("t1_mem_wr_data", mem_wr_data, 16'h3A5C);
    check("t1_rd_ready", rd_ready, 1);
    @(negedge clk);
    rd_valid = 0; #1;
    check("t1_mem_rd_en_issue", mem_rd_en, 1);
    check("t1_mem_wr_en_rd", mem_wr_en, 0);
    check("t1_mem_addr_rd", mem_addr, 10'h155);
    check("t1_busy", busy, 1);
    check("t1_rsp_early1", rsp_valid, 0);
    @(negedge clk); #1;
    check("t1_rsp_early2", rsp_valid, 0);
    check("t1_idle_chip_en", mem_chip_en, 0);
    check("t1_addr_hold", mem_addr, 10'h155);
    @(negedge clk); #1;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_data", rsp_data, 16'h3A5C);
    rsp_ready = 1;
    @(negedge clk); #1;
    check("t1_rsp_popped", rsp_valid, 0);
    check("t1_busy_done", busy, 0);

    // 2: both streams valid for 6 cycles from reset -> W,R,W,R,W,R
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nw = 0; nr = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr_valid = (k < 6); rd_valid = (k < 6);
      wr_addr  = 10'h100 + 10'(nw);
      wr_data  = 16'hA000 + 16'(nw);
      rd_addr  = 10'h100 + 10'(nr);
      #1;
      if (k < 6) begin
        check($sformatf("t2_wr_ready_k%0d", k), wr_ready, 32'((k % 2) == 0));
        check($sformatf("t2_rd_ready_k%0d", k), rd_ready, 32'((k % 2) == 1));
      end
      if (k >= 1 && k <= 6) begin
        check($sformatf("t2_chip_en_k%0d", k), mem_chip_en, 1);
        check($sformatf("t2_wr_en_k%0d", k), mem_wr_en, 32'(((k - 1) % 2) == 0));
        check($sformatf("t2_rd_en_k%0d", k), mem_rd_en, 32'(((k - 1) % 2) == 1));
        check($sformatf("t2_addr_k%0d", k), mem_addr, 32'h100 + 32'((k - 1) / 2));
      end else if (k == 7) begin
        check("t2_chip_en_idle", mem_chip_en, 0);
      end
      if (k == 4 || k == 6 || k == 8) begin
        check($sformatf("t2_rsp_valid_k%0d", k), rsp_valid, 1);
        check($sformatf("t2_rsp_data_k%0d", k), rsp_data, 32'hA000 + 32'((k - 4) / 2));
      end else begin
        check($sformatf("t2_rsp_idle_k%0d", k), rsp_valid, 0);
      end
      if (wr_valid && wr_ready) nw++;
      if (rd_valid && rd_ready) nr++;
    end

    // 3: consumer stalled, 8 reads offered -> exactly 4 accepted
    @(negedge clk);
    rsp_ready = 0; #1;
    check("t3_start_busy", busy, 0);
    na = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rd_valid = 1; rd_addr = addr_tab[na % 4]; #1;
      check($sformatf("t3_rd_ready_k%0d", k), rd_ready, 32'(k < 4));
      if (rd_ready) na++;
    end
    @(negedge clk);
    rd_valid = 0; rsp_ready = 1; #1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("t3_pop_valid_%0d", j), rsp_valid, 1);
      check($sformatf("t3_pop_data_%0d", j), rsp_data, data_tab[j]);
      @(negedge clk); #1;
    end
    check("t3_drained", rsp_valid, 0);
    rd_valid = 1; rd_addr = 10'h155; #1;
    check("t3_rd_ready_back", rd_ready, 1);
    @(negedge clk);
    rd_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    check("t3_late_rsp_valid", rsp_valid, 1);
    check("t3_late_rsp_data", rsp_data, 16'h3A5C);

    // 4: back-to-back reads with a free-running consumer
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rd_valid = (k < 8); rd_addr = addr_tab[k % 4]; #1;
      if (k < 8) check($sformatf("t4_rd_ready_k%0d", k), rd_ready, 1);
      if (k >= 3 && k <= 10) begin
        check($sformatf("t4_rsp_valid_k%0d", k), rsp_valid, 1);
        check($sformatf("t4_rsp_data_k%0d", k), rsp_data, data_tab[(k - 3) % 4]);
        check($sformatf("t4_fifo_count_k%0d", k), 32'(dut.fifo_count_q), 1);
      end else begin
        check($sformatf("t4_rsp_idle_k%0d", k), rsp_valid, 0);
      end
    end

    // 5: reset with one response queued and two reads in flight
    rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rd_valid = 1; rd_addr = addr_tab[k]; #1;
      check($sformatf("t5_rd_ready_k%0d", k), rd_ready, 1);
    end
    @(negedge clk);
    rd_valid = 0; #1;
    check("t5_pre_rsp_valid", rsp_valid, 1);
    check("t5_pre_rd_en", mem_rd_en, 1);
    check("t5_pre_busy", busy, 1);
    rst_n = 1'b0; rd_valid = 1; #1;
    check("t5_rst_chip_en", mem_chip_en, 0);
    check("t5_rst_rd_en", mem_rd_en, 0);
    check("t5_rst_addr", mem_addr, 0);
    check("t5_rst_rsp_valid", rsp_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rd_ready", rd_ready, 0);
    rd_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check($sformatf("t5_no_stale_k%0d", k), rsp_valid, 0);
      check($sformatf("t5_idle_busy_k%0d", k), busy, 0);
    end

    // 6: RD_LAT=3 build, single read of a preloaded word
    @(negedge clk);
    rd_valid3 = 1; rd_addr3 = 10'h2AA; #1;
    check("t6_rd_ready", rd_ready3, 1);
    for (int d = 1; d <= 5; d++) begin
      @(negedge clk);
      rd_valid3 = 0; #1;
      if (d == 1) check("t6_mem_rd_en", mem_rd_en3, 1);
      if (d < 5) begin
        check($sformatf("t6_rsp_early_d%0d", d), rsp_valid3, 0);
      end else begin
        check("t6_rsp_valid", rsp_valid3, 1);
        check("t6_rsp_data", rsp_data3, 16'hBEEF);
      end
    end
    rsp_ready3 = 1;
    @(negedge clk); #1;
    check("t6_popped", rsp_valid3, 0);
    check("t6_busy", busy3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
